// File: rtl/scmp_arb_pak.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : scmp_arb_pak                                                 |
// | Description : Shared types and constants for the SC/MP bus arbiter:        |
// |               arbiter state encoding, bus owner encoding and the width     |
// |               of the wait-state counter.                                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package scmp_arb_pak;

  // Wide enough for the legal WAIT_STATES range 0..7.
  localparam int WS_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } ARB_STATE_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_AUX = 1'b1
  } ARB_OWNER_t;

endpackage
`default_nettype wire

// File: rtl/scmp_arb_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : scmp_arb_port                                                |
// | Description : Per-master return path. Captures read data and raises a      |
// |               one-cycle ack when the cycle owned by this master completes. |
// | Ports       : clk, rst        clock / async active-high reset              |
// |               i_sel           this master owns the current bus cycle       |
// |               i_done          final strobe cycle completes on this edge    |
// |               i_rd            current cycle is a read                      |
// |               i_din [7:0]     bus read data                                |
// |               o_ack           completion pulse (high during DONE)          |
// |               o_rdata [7:0]   last read data for this master               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module scmp_arb_port (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sel,
  input  logic       i_done,
  input  logic       i_rd,
  input  logic [7:0] i_din,
  output logic       o_ack,
  output logic [7:0] o_rdata
);

  logic       r_ack;
  logic [7:0] r_rdata;

  // Registered on the leaving edge of ACCESS, so the ack lands in DONE and an
  // access aborted by reset never produces one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_rdata <= 8'h00;
    end else begin
      r_ack <= i_done & i_sel;
      if (i_done && i_sel && i_rd) begin
        r_rdata <= i_din;
      end
    end
  end

  assign o_ack   = r_ack;
  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/scmp_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : scmp_bus_arbiter                                             |
// | Description : Shares one 8-bit SC/MP-style memory bus between the CPU      |
// |               (port C) and an auxiliary master (port X). Each access is    |
// |               an address strobe followed by a read/write strobe of         |
// |               WAIT_STATES+1 cycles (extendable by mem_hold), then a        |
// |               one-cycle ack to the granted master.                         |
// | Config      : SCMP_ARB_ROUND_ROBIN_EN - when defined, simultaneous          |
// |               requests alternate; otherwise the CPU always wins.           |
// | Ports       : cpu_*/aux_*  request interfaces (req/we/addr/wdata/ack/rdata)|
// |               mem_*        external bus (addr/dout/din/strobes/hold)       |
// |               busy         not IDLE;  owner  0=CPU 1=aux (current/last)    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module scmp_bus_arbiter
  import scmp_arb_pak::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [7:0]        aux_wdata,
  output logic              aux_ack,
  output logic [7:0]        aux_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  output logic              mem_ads_n,
  output logic              mem_rd_n,
  output logic              mem_wr_n,
  input  logic              mem_hold,
  output logic              busy,
  output logic              owner
);

  localparam logic [WS_CNT_W-1:0] c_ws = WAIT_STATES[WS_CNT_W-1:0];

  ARB_STATE_t          r_state;
  ARB_STATE_t          w_state_nxt;
  ARB_OWNER_t          r_owner;
  ARB_OWNER_t          w_win;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_dout;
  logic [WS_CNT_W-1:0] r_cnt;
  logic                w_any_req;
  logic                w_done;

  assign w_any_req = cpu_req | aux_req;

`ifdef SCMP_ARB_ROUND_ROBIN_EN
  // Last granted master; reset to aux so the first contested grant is CPU.
  ARB_OWNER_t r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= OWN_AUX;
    end else if (r_state == IDLE && w_any_req) begin
      r_last <= w_win;
    end
  end

  assign w_win = (cpu_req && aux_req) ? ((r_last == OWN_CPU) ? OWN_AUX : OWN_CPU)
                                      : (cpu_req ? OWN_CPU : OWN_AUX);
`else
  assign w_win = cpu_req ? OWN_CPU : OWN_AUX;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = ADDR;
      ADDR:    w_state_nxt = ACCESS;
      ACCESS: begin
        // Counter at zero marks the final strobe cycle; hold stretches it.
        if (r_cnt == '0 && !mem_hold) begin
          w_state_nxt = DONE;
          w_done      = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request attributes are captured at grant so the bus stays stable even if
  // the master changes or drops its request mid-access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= OWN_CPU;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_dout  <= 8'h00;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner <= w_win;
            if (w_win == OWN_CPU) begin
              r_we   <= cpu_we;
              r_addr <= cpu_addr;
              r_dout <= cpu_we ? cpu_wdata : 8'h00;
            end else begin
              r_we   <= aux_we;
              r_addr <= aux_addr;
              r_dout <= aux_we ? aux_wdata : 8'h00;
            end
          end
        end
        ADDR:    r_cnt <= c_ws;
        ACCESS:  if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset releases them
  // immediately.
  assign mem_ads_n = (r_state != ADDR);
  assign mem_rd_n  = !((r_state == ACCESS) && !r_we);
  assign mem_wr_n  = !((r_state == ACCESS) && r_we);
  assign mem_addr  = r_addr;
  assign mem_dout  = r_dout;
  assign busy      = (r_state != IDLE);
  assign owner     = r_owner;

  scmp_arb_port u_port_cpu (
    .clk     (clk),
    .rst     (rst),
    .i_sel   (r_owner == OWN_CPU),
    .i_done  (w_done),
    .i_rd    (!r_we),
    .i_din   (mem_din),
    .o_ack   (cpu_ack),
    .o_rdata (cpu_rdata)
  );

  scmp_arb_port u_port_aux (
    .clk     (clk),
    .rst     (rst),
    .i_sel   (r_owner == OWN_AUX),
    .i_done  (w_done),
    .i_rd    (!r_we),
    .i_din   (mem_din),
    .o_ack   (aux_ack),
    .o_rdata (aux_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_scmp_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_scmp_bus_arbiter                                          |
// | Description : Self-checking bench for scmp_bus_arbiter. Stimulus pushes    |
// |               expected transactions into a scoreboard queue; a monitor     |
// |               tracks the bus and pops/compares on every ack. A second      |
// |               instance with WAIT_STATES=0 covers the short-cycle case.     |
// | Config      : SCMP_ARB_ROUND_ROBIN_EN selects the expected grant order.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_scmp_bus_arbiter;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, aux_req, aux_we;
  logic [15:0] cpu_addr, aux_addr, mem_addr;
  logic [7:0]  cpu_wdata, aux_wdata, cpu_rdata, aux_rdata;
  logic        cpu_ack, aux_ack;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din = 8'h00;
  logic        mem_ads_n, mem_rd_n, mem_wr_n, busy, owner;
  logic        mem_hold = 1'b0;

  // WAIT_STATES=0 instance
  logic        z_req, z_we, z_ack, z_aack, z_ads_n, z_rd_n, z_wr_n, z_busy, z_owner;
  logic [15:0] z_addr, z_maddr;
  logic [7:0]  z_rdata, z_ardata, z_dout;

  always #5 clk = ~clk;

  scmp_bus_arbiter #(.WAIT_STATES(WS), .ADDR_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_ads_n(mem_ads_n), .mem_rd_n(mem_rd_n), .mem_wr_n(mem_wr_n),
    .mem_hold(mem_hold), .busy(busy), .owner(owner)
  );

  scmp_bus_arbiter #(.WAIT_STATES(0), .ADDR_W(16)) u_dut0 (
    .clk(clk), .rst(rst),
    .cpu_req(z_req), .cpu_we(z_we), .cpu_addr(z_addr), .cpu_wdata(8'h00),
    .cpu_ack(z_ack), .cpu_rdata(z_rdata),
    .aux_req(1'b0), .aux_we(1'b0), .aux_addr(16'h0000), .aux_wdata(8'h00),
    .aux_ack(z_aack), .aux_rdata(z_ardata),
    .mem_addr(z_maddr), .mem_dout(z_dout), .mem_din(8'h77),
    .mem_ads_n(z_ads_n), .mem_rd_n(z_rd_n), .mem_wr_n(z_wr_n),
    .mem_hold(1'b0), .busy(z_busy), .owner(z_owner)
  );

  typedef struct {
    int          port;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          hold;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] exp_rd [2];
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         hold_cfg = 0;
  logic [7:0] din_cfg = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
  endfunction

  function automatic void expect_txn(int p, logic we, logic [15:0] a, logic [7:0] wd,
                                     logic [7:0] din, int hold);
    exp_t e;
    if (!we) exp_rd[p] = din;
    e.port = p; e.we = we; e.addr = a; e.wdata = wd; e.rdata = exp_rd[p]; e.hold = hold;
    sbq.push_back(e);
  endfunction

  // Slave: asserts hold for hold_cfg cycles starting at the final strobe
  // cycle, returning junk while holding so a premature sample is visible.
  int s_cnt = 0, s_held = 0;
  always @(negedge clk) begin
    if (!mem_rd_n || !mem_wr_n) begin
      s_cnt++;
      if (s_cnt >= WS + 1 && s_held < hold_cfg) begin
        mem_hold = 1'b1;
        s_held++;
      end else begin
        mem_hold = 1'b0;
      end
    end else begin
      s_cnt = 0; s_held = 0; mem_hold = 1'b0;
    end
    mem_din = mem_hold ? 8'hEE : din_cfg;
  end

  // Monitor: bus tracking and scoreboard pop on ack.
  int          a_cyc = 0, st_first = 0, s_len = 0, p;
  logic [15:0] a_addr = '0;
  logic [7:0]  d_first = '0;
  logic        addr_ok = 1'b1, dout_ok = 1'b1, s_we = 1'b0;
  exp_t        m_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (!mem_ads_n) begin
        a_cyc = cyc; a_addr = mem_addr; s_len = 0; addr_ok = 1'b1; dout_ok = 1'b1;
      end
      if (!mem_rd_n || !mem_wr_n) begin
        if (s_len == 0) begin st_first = cyc; d_first = mem_dout; end
        s_len++;
        if (mem_addr !== a_addr) addr_ok = 1'b0;
        if (mem_dout !== d_first) dout_ok = 1'b0;
        s_we = !mem_wr_n;
      end
      if (cpu_ack || aux_ack) begin
        p = aux_ack ? 1 : 0;
        chk("single_ack", {31'd0, cpu_ack & aux_ack}, 32'd0);
        if (sbq.size() == 0) begin
          chk("unexpected_ack", sbq.size(), 1);
        end else begin
          m_e = sbq.pop_front();
          chk("ack_port", p, m_e.port);
          chk("owner", {31'd0, owner}, m_e.port);
          chk("addr", {16'd0, a_addr}, {16'd0, m_e.addr});
          chk("we", {31'd0, s_we}, {31'd0, m_e.we});
          chk("strobe_len", s_len, WS + 1 + m_e.hold);
          chk("strobe_start", st_first, a_cyc + 1);
          chk("ack_latency", cyc - a_cyc + 1, WS + 3 + m_e.hold);
          chk("addr_stable", {31'd0, addr_ok}, 32'd1);
          chk("dout", {24'd0, d_first}, {24'd0, m_e.we ? m_e.wdata : 8'h00});
          chk("dout_stable", {31'd0, dout_ok}, 32'd1);
          chk("rdata", {24'd0, p ? aux_rdata : cpu_rdata}, {24'd0, m_e.rdata});
        end
      end
    end
  end

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [15:0] a, input logic [7:0] wd);
    if (port == 0) begin cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    else           begin aux_req = req; aux_we = we; aux_addr = a; aux_wdata = wd; end
  endtask

  task automatic set_req(input int port, input logic req);
    if (port == 0) cpu_req = req; else aux_req = req;
  endtask

  // Master model: keeps req high until each ack, optionally dropping it once
  // the access strobe is running.
  task automatic run_master(input int port, input int n, input logic we,
                            input logic [15:0] base, input logic [7:0] wd, input bit drop_mid);
    for (int i = 0; i < n; i++) begin
      bit got = 1'b0;
      drive(port, 1'b1, we, 16'(base + i), wd);
      for (int k = 0; k < 200 && !got; k++) begin
        @(posedge clk); #1;
        if (drop_mid && (!mem_rd_n || !mem_wr_n)) set_req(port, 1'b0);
        if ((port == 0) ? cpu_ack : aux_ack) got = 1'b1;
      end
      chk("ack_timeout", {31'd0, got}, 32'd1);
    end
    set_req(port, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] tr;
    bit          seen;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 8'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 8'h0);
    z_req = 1'b0; z_we = 1'b0; z_addr = 16'h0;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", {29'd0, mem_ads_n, mem_rd_n, mem_wr_n}, 32'h7);
    chk("rst_addr_dout", {8'd0, mem_addr, mem_dout}, 32'd0);
    chk("rst_ack_rdata", {14'd0, cpu_ack, aux_ack, cpu_rdata, aux_rdata}, 32'd0);
    chk("rst_owner_busy", {30'd0, owner, busy}, 32'd0);
    rst = 1'b0;

    // CPU read
    din_cfg = 8'h5A;
    expect_txn(0, 1'b0, 16'h0123, 8'h00, 8'h5A, 0);
    run_master(0, 1, 1'b0, 16'h0123, 8'h00, 1'b0);

    // Aux read then aux write (write must not disturb aux_rdata)
    din_cfg = 8'h96;
    expect_txn(1, 1'b0, 16'h0456, 8'h00, 8'h96, 0);
    run_master(1, 1, 1'b0, 16'h0456, 8'h00, 1'b0);
    expect_txn(1, 1'b1, 16'hF800, 8'hC3, 8'h00, 0);
    run_master(1, 1, 1'b1, 16'hF800, 8'hC3, 1'b0);

    // Contention: three transactions per master
    din_cfg = 8'h3C;
`ifdef SCMP_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 3; i++) begin
      expect_txn(0, 1'b0, 16'(16'h1000 + i), 8'h00, 8'h3C, 0);
      expect_txn(1, 1'b0, 16'(16'h2000 + i), 8'h00, 8'h3C, 0);
    end
`else
    for (int i = 0; i < 3; i++) expect_txn(0, 1'b0, 16'(16'h1000 + i), 8'h00, 8'h3C, 0);
    for (int i = 0; i < 3; i++) expect_txn(1, 1'b0, 16'(16'h2000 + i), 8'h00, 8'h3C, 0);
`endif
    fork
      run_master(0, 3, 1'b0, 16'h1000, 8'h00, 1'b0);
      run_master(1, 3, 1'b0, 16'h2000, 8'h00, 1'b0);
    join

    // Slave hold for 3 cycles on the final strobe cycle
    din_cfg = 8'hA7; hold_cfg = 3;
    expect_txn(0, 1'b0, 16'h0ABC, 8'h00, 8'hA7, 3);
    run_master(0, 1, 1'b0, 16'h0ABC, 8'h00, 1'b0);
    hold_cfg = 0;

    // Async reset in the middle of ACCESS
    din_cfg = 8'h81;
    drive(0, 1'b1, 1'b0, 16'h0777, 8'h00);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (!mem_rd_n) seen = 1'b1;
    end
    chk("rd_strobe_seen", {31'd0, seen}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {29'd0, mem_ads_n, mem_rd_n, mem_wr_n}, 32'h7);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_rdata", {24'd0, cpu_rdata}, 32'd0);
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    @(posedge clk); #1;
    chk("rst_mid_noack", {30'd0, cpu_ack, aux_ack}, 32'd0);
    #2 rst = 1'b0;
    expect_txn(0, 1'b0, 16'h0777, 8'h00, 8'h81, 0);
    run_master(0, 1, 1'b0, 16'h0777, 8'h00, 1'b0);

    // Request dropped during ACCESS still completes
    din_cfg = 8'h4D;
    expect_txn(0, 1'b0, 16'h0321, 8'h00, 8'h4D, 0);
    run_master(0, 1, 1'b0, 16'h0321, 8'h00, 1'b1);

    // WAIT_STATES=0: trace {ads_n, rd_n, ack} over four cycles, req dropped in ACCESS
    @(posedge clk); #1;
    z_req = 1'b1; z_we = 1'b0; z_addr = 16'h0042;
    tr = '0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      tr = {tr[8:0], z_ads_n, z_rd_n, z_ack};
      if (c == 2) z_req = 1'b0;
    end
    chk("ws0_trace", {20'd0, tr}, {20'd0, 12'b010_100_111_110});
    chk("ws0_rdata_addr", {z_maddr, z_rdata, 8'd0}, {16'h0042, 8'h77, 8'd0});

    // Drain the scoreboard
    for (int k = 0; k < 50 && sbq.size() != 0; k++) @(posedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
